// File: rtl/led_frame_sequencer.sv
// Multi-frame addressable-LED sequencer: pattern RAM, brightness scaling,
// latch gap insertion and frame animation over a start/done word handshake.
module led_frame_sequencer #(
  parameter  int NUM_LEDS     = 16,
  parameter  int NUM_FRAMES   = 4,
  parameter  int RESET_CYCLES = 15000,
  localparam int DEPTH        = NUM_LEDS * NUM_FRAMES,
  localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW           = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          run,
  input  logic          loop_mode,
  input  logic [7:0]    frame_hold,
  input  logic [7:0]    bright,
  output logic          tx_start,
  output logic [23:0]   tx_data,
  input  logic          tx_done,
  output logic          latch,
  output logic          busy,
  output logic [FW-1:0] frame_idx,
  output logic          seq_done
);

  // state  | meaning
  // IDLE   | stopped, waiting for run
  // LOAD   | RAM address presented for current pixel
  // SCALE  | RAM word available, scaled word registered
  // SEND   | tx_start pulse
  // WAIT   | waiting for serializer tx_done
  // GAP    | latch gap, RESET_CYCLES cycles
  // ADV    | refresh/frame bookkeeping
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SCALE, S_SEND, S_WAIT, S_GAP, S_ADV
  } state_t;

  localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CW = $clog2(RESET_CYCLES + 1);

  state_t        state;
  logic [LW-1:0] led;
  logic [7:0]    refresh_cnt;
  logic [CW-1:0] gap_cnt;
  logic          seq_end;
  logic [23:0]   ram_q;
  logic [23:0]   mem [DEPTH];

  logic [AW-1:0] rd_addr;
  logic          wr_ok;
  logic [7:0]    hold_eff;
  logic [8:0]    refresh_nxt;
  logic          last_refresh;
  logic          last_frame;

  assign rd_addr      = AW'(32'(frame_idx) * NUM_LEDS + 32'(led));
  assign wr_ok        = 32'(wr_addr) < DEPTH;
  assign hold_eff     = (frame_hold == 8'd0) ? 8'd1 : frame_hold;
  assign refresh_nxt  = {1'b0, refresh_cnt} + 9'd1;
  assign last_refresh = refresh_nxt >= {1'b0, hold_eff};
  assign last_frame   = frame_idx == FW'(NUM_FRAMES - 1);

  function automatic logic [7:0] scale8(input logic [7:0] b, input logic [7:0] k);
    logic [15:0] p;
    p = {8'd0, b} * ({8'd0, k} + 16'd1);
    return p[15:8];
  endfunction

  // Nonblocking read and write give read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
    if (state == S_LOAD) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      led         <= '0;
      refresh_cnt <= '0;
      gap_cnt     <= '0;
      seq_end     <= 1'b0;
      frame_idx   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      latch       <= 1'b0;
      busy        <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_LOAD;
            busy  <= 1'b1;
            led   <= '0;
            if (seq_end) begin
              frame_idx   <= '0;
              refresh_cnt <= '0;
              seq_end     <= 1'b0;
            end
          end
        end
        S_LOAD: state <= S_SCALE;
        S_SCALE: begin
          tx_data  <= {scale8(ram_q[23:16], bright), scale8(ram_q[15:8], bright),
                       scale8(ram_q[7:0], bright)};
          tx_start <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          tx_start <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (led != LW'(NUM_LEDS - 1)) begin
              led   <= led + 1'b1;
              state <= S_LOAD;
            end else begin
              gap_cnt <= '0;
              latch   <= 1'b1;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == CW'(RESET_CYCLES - 1)) begin
            latch    <= 1'b0;
            // Decided here so the pulse lines up with the ADV cycle.
            seq_done <= last_refresh && last_frame && !loop_mode;
            state    <= S_ADV;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_ADV: begin
          led      <= '0;
          seq_done <= 1'b0;
          if (seq_done) begin
            refresh_cnt <= '0;
            seq_end     <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            if (last_refresh) begin
              refresh_cnt <= '0;
              frame_idx   <= last_frame ? '0 : frame_idx + 1'b1;
            end else begin
              refresh_cnt <= refresh_nxt[7:0];
            end
            if (run) begin
              state <= S_LOAD;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: 4 LEDs x 2 frames, 20-cycle gap,
// serializer answering tx_done 30 cycles after each tx_start.
module tb_led_frame_sequencer;
  localparam int NL = 4;
  localparam int NF = 2;
  localparam int RC = 20;

  logic        clk, rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        run, loop_mode;
  logic [7:0]  frame_hold, bright;
  logic        tx_start, latch, busy, seq_done;
  logic [23:0] tx_data;
  logic [0:0]  frame_idx;
  logic        ser_done, man_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          st_cyc   [32];
  logic [23:0] st_data  [32];
  int          st_frame [32];
  int          lat_cnt  [32];
  int          sd_cnt;

  logic inj_en = 1'b0;
  logic inj_gap_used = 1'b0;
  logic inj_scale_used = 1'b0;

  led_frame_sequencer #(.NUM_LEDS(NL), .NUM_FRAMES(NF), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .loop_mode(loop_mode), .frame_hold(frame_hold), .bright(bright),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(ser_done | man_done),
    .latch(latch), .busy(busy), .frame_idx(frame_idx), .seq_done(seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serializer: tx_done one cycle, 30 cycles after tx_start.
  initial begin
    ser_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat (30) @(posedge clk);
        #1 ser_done = 1'b1;
        @(posedge clk);
        #1 ser_done = 1'b0;
      end
    end
  end

  // Spurious tx_done injector: once in the SCALE of pixel 1, once mid-gap.
  initial begin
    man_done = 1'b0;
    forever begin
      @(negedge clk);
      if (inj_en && !inj_gap_used && latch) begin
        repeat (5) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        inj_gap_used = 1'b1;
      end else if (inj_en && !inj_scale_used && tx_start) begin
        repeat (32) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        inj_scale_used = 1'b1;
      end
    end
  end

  function automatic logic [23:0] exp_word(input int f, input int l);
    logic [23:0] w;
    case (l)
      0: w = 24'hFF0000;
      1: w = 24'h00FF00;
      2: w = 24'h0000FF;
      default: w = 24'hFFFFFF;
    endcase
    return (f == 1) ? ~w : w;
  endfunction

  task automatic write_ram(input int a, input logic [23:0] d);
    wr_addr = 3'(a);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic capture(input int n, input int max_cyc, output int got);
    got = 0;
    sd_cnt = 0;
    for (int i = 0; i < 32; i++) lat_cnt[i] = 0;
    for (int c = 0; c < max_cyc && got < n; c++) begin
      @(negedge clk);
      if (latch) lat_cnt[got]++;
      if (seq_done) sd_cnt++;
      if (tx_start) begin
        st_cyc[got]   = cyc;
        st_data[got]  = tx_data;
        st_frame[got] = int'(frame_idx);
        got++;
      end
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 400 && busy; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_start, latch, busy, seq_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000", {tx_start, latch, busy, seq_done});
    end
    checks++;
    if (tx_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_tx_data: got %h want 000000", tx_data);
    end
    checks++;
    if (frame_idx !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_idx: got %0d want 0", frame_idx);
    end
  endtask

  task automatic test_loop();
    int got, c0;
    loop_mode = 1'b1; frame_hold = 8'd1; bright = 8'd255;
    c0 = cyc;
    run = 1'b1;
    capture(12, 600, got);
    run = 1'b0;
    checks++;
    if (got !== 12) begin
      errors++;
      $display("FAIL loop_count: got %0d starts want 12", got);
    end
    checks++;
    if (st_cyc[0] - c0 !== 3) begin
      errors++;
      $display("FAIL loop_latency: got %0d want 3", st_cyc[0] - c0);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (st_data[i] !== exp_word((i / 4) % 2, i % 4)) begin
        errors++;
        $display("FAIL loop_data[%0d]: got %h want %h", i, st_data[i], exp_word((i / 4) % 2, i % 4));
      end
      checks++;
      if (st_frame[i] !== (i / 4) % 2) begin
        errors++;
        $display("FAIL loop_frame[%0d]: got %0d want %0d", i, st_frame[i], (i / 4) % 2);
      end
      checks++;
      if (lat_cnt[i] !== ((i % 4 == 0 && i > 0) ? RC : 0)) begin
        errors++;
        $display("FAIL loop_latch[%0d]: got %0d want %0d", i, lat_cnt[i], (i % 4 == 0 && i > 0) ? RC : 0);
      end
      if (i > 0) begin
        checks++;
        if (st_cyc[i] - st_cyc[i-1] !== ((i % 4 == 0) ? 54 : 33)) begin
          errors++;
          $display("FAIL loop_gap[%0d]: got %0d want %0d", i, st_cyc[i] - st_cyc[i-1], (i % 4 == 0) ? 54 : 33);
        end
      end
    end
    wait_idle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: busy=%b want 0", busy);
    end
  endtask

  task automatic test_bright();
    int got;
    pulse_rst();
    write_ram(0, 24'hFF8001);
    bright = 8'd127;
    run = 1'b1;
    capture(1, 50, got);
    bright = 8'd0;
    checks++;
    if (got !== 1 || st_data[0] !== 24'h7F4000) begin
      errors++;
      $display("FAIL bright127: got %h (n=%0d) want 7f4000", st_data[0], got);
    end
    capture(1, 50, got);
    run = 1'b0;
    checks++;
    if (got !== 1 || st_data[0] !== 24'h000000) begin
      errors++;
      $display("FAIL bright0: got %h (n=%0d) want 000000", st_data[0], got);
    end
    wait_idle();
    bright = 8'd255;
    write_ram(0, 24'hFF0000);
  endtask

  task automatic test_single_shot();
    int got, sd_cyc, sd_frame, after_busy, n_sd;
    logic sd_busy;
    pulse_rst();
    loop_mode = 1'b0; frame_hold = 8'd2;
    run = 1'b1;
    capture(16, 800, got);
    run = 1'b0;
    checks++;
    if (got !== 16) begin
      errors++;
      $display("FAIL ss_count: got %0d starts want 16", got);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (st_frame[i] !== i / 8 || st_data[i] !== exp_word(i / 8, i % 4)) begin
        errors++;
        $display("FAIL ss_word[%0d]: got f%0d %h want f%0d %h", i, st_frame[i], st_data[i], i / 8, exp_word(i / 8, i % 4));
      end
    end
    n_sd = 0; sd_cyc = -1; sd_frame = -1; sd_busy = 1'b0; after_busy = -1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (n_sd == 1 && after_busy < 0) after_busy = int'(busy);
      if (seq_done) begin
        n_sd++;
        if (n_sd == 1) begin
          sd_cyc = cyc; sd_frame = int'(frame_idx); sd_busy = busy;
        end
      end
      if (tx_start) n_sd = n_sd + 100;
    end
    checks++;
    if (n_sd !== 1) begin
      errors++;
      $display("FAIL ss_done_count: got %0d want 1", n_sd);
    end
    checks++;
    if (sd_cyc - st_cyc[15] !== 51) begin
      errors++;
      $display("FAIL ss_done_time: got %0d want 51", sd_cyc - st_cyc[15]);
    end
    checks++;
    if (sd_frame !== 1 || sd_busy !== 1'b1 || after_busy !== 0) begin
      errors++;
      $display("FAIL ss_done_state: frame %0d busy %b next_busy %0d want 1 1 0", sd_frame, sd_busy, after_busy);
    end
    checks++;
    if (frame_idx !== 1'b1) begin
      errors++;
      $display("FAIL ss_hold_frame: got %0d want 1", frame_idx);
    end
    run = 1'b1;
    capture(1, 50, got);
    run = 1'b0;
    checks++;
    if (got !== 1 || st_frame[0] !== 0 || st_data[0] !== 24'hFF0000) begin
      errors++;
      $display("FAIL ss_restart: got f%0d %h want f0 ff0000", st_frame[0], st_data[0]);
    end
    wait_idle();
  endtask

  task automatic test_stop_resume();
    int got;
    pulse_rst();
    loop_mode = 1'b1; frame_hold = 8'd2;
    run = 1'b1;
    capture(2, 100, got);
    run = 1'b0;
    capture(3, 200, got);
    checks++;
    if (got !== 2 || st_data[0] !== 24'h0000FF || st_data[1] !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL stop_tail: n=%0d %h %h want 2 0000ff ffffff", got, st_data[0], st_data[1]);
    end
    checks++;
    if (lat_cnt[2] !== RC) begin
      errors++;
      $display("FAIL stop_gap: got %0d want %0d", lat_cnt[2], RC);
    end
    checks++;
    if (busy !== 1'b0 || frame_idx !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: busy %b frame %0d want 0 0", busy, frame_idx);
    end
    run = 1'b1;
    capture(1, 50, got);
    run = 1'b0;
    checks++;
    if (got !== 1 || st_frame[0] !== 0 || st_data[0] !== 24'hFF0000) begin
      errors++;
      $display("FAIL stop_resume: got f%0d %h want f0 ff0000", st_frame[0], st_data[0]);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_gap();
    int got, c0, w;
    pulse_rst();
    loop_mode = 1'b1; frame_hold = 8'd1;
    run = 1'b1;
    capture(4, 200, got);
    run = 1'b0;
    w = 0;
    while (!latch && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (latch !== 1'b1) begin
      errors++;
      $display("FAIL rgap_enter: latch %b want 1", latch);
    end
    repeat (5) @(negedge clk);
    pulse_rst();
    checks++;
    if ({tx_start, latch, busy, seq_done} !== 4'b0 || tx_data !== 24'h0 || frame_idx !== 1'b0) begin
      errors++;
      $display("FAIL rgap_outputs: strobes %b data %h frame %0d want 0000 000000 0",
               {tx_start, latch, busy, seq_done}, tx_data, frame_idx);
    end
    c0 = cyc;
    run = 1'b1;
    capture(2, 100, got);
    run = 1'b0;
    checks++;
    if (got !== 2 || st_cyc[0] - c0 !== 3 || st_frame[0] !== 0 ||
        st_data[0] !== 24'hFF0000 || st_data[1] !== 24'h00FF00) begin
      errors++;
      $display("FAIL rgap_restart: n=%0d lat %0d f%0d %h %h want 2 3 f0 ff0000 00ff00",
               got, st_cyc[0] - c0, st_frame[0], st_data[0], st_data[1]);
    end
    wait_idle();
  endtask

  task automatic test_spurious();
    int got;
    pulse_rst();
    loop_mode = 1'b1; frame_hold = 8'd1;
    inj_en = 1'b1;
    run = 1'b1;
    capture(5, 300, got);
    run = 1'b0;
    inj_en = 1'b0;
    checks++;
    if (got !== 5) begin
      errors++;
      $display("FAIL spur_count: got %0d want 5", got);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (st_cyc[i] - st_cyc[i-1] !== ((i == 4) ? 54 : 33)) begin
        errors++;
        $display("FAIL spur_gap[%0d]: got %0d want %0d", i, st_cyc[i] - st_cyc[i-1], (i == 4) ? 54 : 33);
      end
    end
    checks++;
    if (lat_cnt[4] !== RC || st_frame[4] !== 1 || st_data[4] !== 24'h00FFFF) begin
      errors++;
      $display("FAIL spur_next: latch %0d f%0d %h want %0d f1 00ffff", lat_cnt[4], st_frame[4], st_data[4], RC);
    end
    checks++;
    if (st_data[1] !== 24'h00FF00) begin
      errors++;
      $display("FAIL spur_pix1: got %h want 00ff00", st_data[1]);
    end
    wait_idle();
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    run = 1'b0; loop_mode = 1'b1; frame_hold = 8'd1; bright = 8'd255;
    @(negedge clk);
    test_reset();
    for (int f = 0; f < NF; f++)
      for (int l = 0; l < NL; l++)
        write_ram(f * NL + l, exp_word(f, l));
    test_loop();
    test_bright();
    test_single_shot();
    test_stop_resume();
    test_reset_mid_gap();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
